rf_ctrl: RTL
============

RF_CTRL -- requirements
Module: rf_ctrl

Interface
REQ-001 SHALL have parameter OP_CYCLES, default 1: number of cycles each operation is held on the rf ports (1..15).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  2  per-requester command valid (bit i = requester i).
REQ-005 SHALL have port req_ready  out  2  per-requester command accept.
REQ-006 SHALL have port req_op  in  4  2-bit opcode per requester ({op1,op0}): 00 read, 01 store, 10 load, 11 nop.
REQ-007 SHALL have ports req_a, req_b, req_w  in  10 each  5-bit register indices per requester (source, base, destination).
REQ-008 SHALL have port req_imm  in  128  64-bit offset/data per requester.
REQ-009 SHALL have port rsp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-010 SHALL have ports rsp_douta, rsp_doutb  out  64 each  read data, qualified by rsp_valid.
REQ-011 SHALL have ports rf_enable, rf_load_store  out  1 each; rf_a, rf_b, rf_w  out  5 each; rf_din  out  64: rf datapath controls.
REQ-012 SHALL have ports rf_douta, rf_doutb  in  64 each  rf combinational read data.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other transitions except reset.
REQ-015 SHALL, in IDLE, assert req_ready only for the round-robin winner among valid requesters; none if no valid.
REQ-016 SHALL use round-robin priority: requester not granted last wins on simultaneous valid; after reset requester 0 has priority.
REQ-017 SHALL latch op/a/b/w/imm and the owner on valid&ready and enter EXEC next cycle.
REQ-018 SHALL stay in EXEC exactly OP_CYCLES cycles, driving rf ports from latched command, stable throughout.
REQ-019 SHALL drive in EXEC: read -> rf_enable=0, rf_a=a, rf_b=b; store -> rf_enable=1, rf_load_store=0, rf_a=a, rf_b=b, rf_din=imm; load -> rf_enable=1, rf_load_store=1, rf_w=w, rf_b=b, rf_din=imm; nop -> all rf outputs idle.
REQ-020 SHALL capture rf_douta/rf_doutb on the last EXEC edge for read ops; rsp data SHALL be 0 for store, load, nop.
REQ-021 SHALL spend one cycle in RESP with rf_enable=0 and rsp_valid[owner]=1, then return to IDLE.
REQ-022 SHALL drive idle rf outputs (IDLE, RESP) as all zero; rf_enable never high outside EXEC.
REQ-023 SHALL accept no new command outside IDLE; throughput one op per OP_CYCLES+2 cycles.
REQ-024 SHALL ignore req_valid deassertion after acceptance; an accepted op always completes unless reset.

Reset
REQ-025 SHALL on reset clear immediately: state IDLE, req_ready=0, rsp_valid=0, rsp data 0, all rf outputs 0, busy=0, priority to requester 0.
REQ-026 SHALL abort an in-flight operation on reset with no rsp_valid issued.

Configuration
REQ-027 SHALL, with RF_CTRL_PERF_EN defined, add outputs perf_ops0 and perf_ops1 (32 bits each) counting completed ops per requester (increment on rsp_valid bit), saturating at all-ones, cleared by reset.
REQ-028 SHALL, without RF_CTRL_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-029 SHALL place opcode encodings, FSM state encoding, REG_ADDR_W=5 and DATA_W=64 in shared package rf_ctrl_pkg.
REQ-030 SHALL implement arbitration in sub-module rr_arbiter2 (2-way round-robin, last-grant register, update on handshake only).

Verification
REQ-031 SHALL check: reset during idle -> all outputs 0; req_valid=01 -> req_ready=01 same cycle.
REQ-032 SHALL check: req0 store a=2 b=0 imm=0 -> next cycle rf_enable=1, rf_load_store=0, rf_a=2, rf_b=0, rf_din=0 for 1 cycle, then rsp_valid=01.
REQ-033 SHALL check: req1 read a=30 b=31 with model rf_douta=2, rf_doutb=4 -> rsp_valid=10, rsp_douta=2, rsp_doutb=4.
REQ-034 SHALL check: req_valid=11 held for 4 ops -> grants 0,1,0,1; load w=31 b=0 imm=8 -> rf_load_store=1, rf_w=31, rf_din=8.
REQ-035 SHALL check: reset asserted mid-EXEC (OP_CYCLES=3) -> rf_enable=0 immediately, no rsp_valid, next grant to requester 0.
REQ-036 SHALL check with RF_CTRL_PERF_EN: 3 ops req0, 1 op req1 -> perf_ops0=3, perf_ops1=1.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the rf_ctrl register-file command controller.
package rf_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 32'd5;
  localparam int unsigned DATA_W     = 32'd64;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_STORE = 2'b01,
    OP_LOAD  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    op_e                   op;
    logic [REG_ADDR_W-1:0] a;
    logic [REG_ADDR_W-1:0] b;
    logic [REG_ADDR_W-1:0] w;
    logic [DATA_W-1:0]     imm;
    logic                  owner;
  } cmd_t;

  typedef struct packed {
    logic                  enable;
    logic                  load_store;
    logic [REG_ADDR_W-1:0] a;
    logic [REG_ADDR_W-1:0] b;
    logic [REG_ADDR_W-1:0] w;
    logic [DATA_W-1:0]     din;
  } rf_drv_t;

  localparam rf_drv_t RF_IDLE = '{enable: 1'b0, load_store: 1'b0, a: 5'd0, b: 5'd0,
                                  w: 5'd0, din: 64'd0};

  localparam cmd_t CMD_NONE = '{op: OP_NOP, a: 5'd0, b: 5'd0, w: 5'd0, imm: 64'd0,
                                owner: 1'b0};

  // Translate a latched command into the rf port values held during EXEC.
  function automatic rf_drv_t rf_drive(input cmd_t c);
    rf_drv_t d;
    d = RF_IDLE;
    case (c.op)
      OP_READ: begin
        d.a = c.a;
        d.b = c.b;
      end
      OP_STORE: begin
        d.enable = 1'b1;
        d.a      = c.a;
        d.b      = c.b;
        d.din    = c.imm;
      end
      OP_LOAD: begin
        d.enable     = 1'b1;
        d.load_store = 1'b1;
        d.w          = c.w;
        d.b          = c.b;
        d.din        = c.imm;
      end
      default: d = RF_IDLE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rf_ctrl_if.sv
// Requester-side command/response bundle for rf_ctrl (two requesters, packed per requester).
interface rf_ctrl_if;
  import rf_ctrl_pkg::*;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_op;
  logic [9:0]   req_a;
  logic [9:0]   req_b;
  logic [9:0]   req_w;
  logic [127:0] req_imm;
  logic [1:0]   rsp_valid;
  logic [63:0]  rsp_douta;
  logic [63:0]  rsp_doutb;

  modport master (
    output req_valid, req_op, req_a, req_b, req_w, req_imm,
    input  req_ready, rsp_valid, rsp_douta, rsp_doutb
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_w, req_imm,
    output req_ready, rsp_valid, rsp_douta, rsp_doutb
  );

endinterface

// File: rtl/rf_ctrl_arb.sv
// Two-way round-robin arbiter; the last-grant register moves only on an accepted handshake.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // last_r = 1 means requester 1 won last, so requester 0 is preferred next.
  logic last_r;

  // Pick the requester that was not granted last when both are valid.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner of each accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= 1'b1;
    end else if (accept) begin
      last_r <= grant[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/rf_ctrl.sv
// rf_ctrl: arbitrates two requesters and sequences each command onto the register-file ports.
// Optional per-requester completion counters are enabled with RF_CTRL_PERF_EN.
module rf_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned OP_CYCLES = 32'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  rf_ctrl_if.slave              bus,
  output logic                  rf_enable,
  output logic                  rf_load_store,
  output logic [REG_ADDR_W-1:0] rf_a,
  output logic [REG_ADDR_W-1:0] rf_b,
  output logic [REG_ADDR_W-1:0] rf_w,
  output logic [DATA_W-1:0]     rf_din,
  input  logic [DATA_W-1:0]     rf_douta,
  input  logic [DATA_W-1:0]     rf_doutb,
  output logic                  busy
`ifdef RF_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_ops0,
  output logic [31:0]           perf_ops1
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(OP_CYCLES - 32'd1);

  state_e            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  cmd_t              cmd_r, cmd_nxt_s, new_cmd_s;
  rf_drv_t           drv_r, drv_nxt_s;
  logic [1:0]        rsp_valid_r, rsp_valid_nxt_s;
  logic [DATA_W-1:0] douta_r, douta_nxt_s;
  logic [DATA_W-1:0] doutb_r, doutb_nxt_s;
  logic [1:0]        grant_s;
  logic              idle_s;
  logic              hs_s;

  // Grants are only offered while idle and out of reset.
  assign idle_s        = (state_r == ST_IDLE) && !reset;
  assign bus.req_ready = idle_s ? grant_s : 2'b00;
  assign hs_s          = idle_s && (grant_s != 2'b00);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req_valid),
    .accept (hs_s),
    .grant  (grant_s)
  );

  // Select the winning requester's command fields.
  always_comb begin
    new_cmd_s = CMD_NONE;
    if (grant_s[1]) begin
      new_cmd_s.op    = op_e'(bus.req_op[3:2]);
      new_cmd_s.a     = bus.req_a[9:5];
      new_cmd_s.b     = bus.req_b[9:5];
      new_cmd_s.w     = bus.req_w[9:5];
      new_cmd_s.imm   = bus.req_imm[127:64];
      new_cmd_s.owner = 1'b1;
    end else begin
      new_cmd_s.op    = op_e'(bus.req_op[1:0]);
      new_cmd_s.a     = bus.req_a[4:0];
      new_cmd_s.b     = bus.req_b[4:0];
      new_cmd_s.w     = bus.req_w[4:0];
      new_cmd_s.imm   = bus.req_imm[63:0];
      new_cmd_s.owner = 1'b0;
    end
  end

  // Next-state and next-output logic; rf ports and response are registered from these.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    cmd_nxt_s       = cmd_r;
    drv_nxt_s       = RF_IDLE;
    rsp_valid_nxt_s = 2'b00;
    douta_nxt_s     = 64'd0;
    doutb_nxt_s     = 64'd0;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          cmd_nxt_s   = new_cmd_s;
          cnt_nxt_s   = 4'd0;
          drv_nxt_s   = rf_drive(new_cmd_s);
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s     = ST_RESP;
          rsp_valid_nxt_s = cmd_r.owner ? 2'b10 : 2'b01;
          // Read data is sampled while rf_a/rf_b are still presented.
          if (cmd_r.op == OP_READ) begin
            douta_nxt_s = rf_douta;
            doutb_nxt_s = rf_doutb;
          end else begin
            douta_nxt_s = 64'd0;
            doutb_nxt_s = 64'd0;
          end
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
          drv_nxt_s = rf_drive(cmd_r);
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, command and registered output updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      cmd_r       <= CMD_NONE;
      drv_r       <= RF_IDLE;
      rsp_valid_r <= 2'b00;
      douta_r     <= 64'd0;
      doutb_r     <= 64'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      cmd_r       <= cmd_nxt_s;
      drv_r       <= drv_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      douta_r     <= douta_nxt_s;
      doutb_r     <= doutb_nxt_s;
    end
  end

  assign rf_enable     = drv_r.enable;
  assign rf_load_store = drv_r.load_store;
  assign rf_a          = drv_r.a;
  assign rf_b          = drv_r.b;
  assign rf_w          = drv_r.w;
  assign rf_din        = drv_r.din;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_douta = douta_r;
  assign bus.rsp_doutb = doutb_r;
  assign busy          = (state_r != ST_IDLE);

`ifdef RF_CTRL_PERF_EN
  // Saturating completion counters, one per requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops0 <= 32'd0;
      perf_ops1 <= 32'd0;
    end else begin
      if (rsp_valid_r[0] && (perf_ops0 != 32'hFFFF_FFFF)) begin
        perf_ops0 <= perf_ops0 + 32'd1;
      end else begin
        perf_ops0 <= perf_ops0;
      end
      if (rsp_valid_r[1] && (perf_ops1 != 32'hFFFF_FFFF)) begin
        perf_ops1 <= perf_ops1 + 32'd1;
      end else begin
        perf_ops1 <= perf_ops1;
      end
    end
  end
`endif

endmodule
